c499_sec: RTL and testbench
===========================

# c499_sec

Registered 32-bit single-error-correcting (SEC) decoder, functionally modelled on the ISCAS-85 c499 benchmark. It takes a 32-bit data word, 8 stored check bits and a correction-enable, and computes an 8-bit syndrome. It flips the one data bit whose Hamming column matches the syndrome, and drives the corrected word from an output register. It sits in the benchmark/aging test harness as the logic under stress, between the vector-driven stimulus registers and the output capture.

## Interface
- No parameters. Data width 32 and check width 8 are fixed.
- clk  in  1  rising-edge clock for the output register.
- rst_n  in  1  asynchronous, active-low reset.
- N1, N5, N9, …, N125  in  1 each  data bits ID0..ID31; ID_i = N(1+4i).
- N129..N136  in  1 each  check bits IC0..IC7; IC_j = N(129+j).
- N137  in  1  R, correction enable.
- N724..N755  out  1 each  corrected data OD0..OD31; OD_i = N(724+i).

## Operation
- The H-matrix column for data bit i is H_i[7:0] = {onehot4(i/8), L(i%8)}.
  - For k = 0..3, L(k) = 1<<k.
  - For k = 4..7, L(k) = 4'hF ^ (1<<(k-4)).
  - Example: H_0 = 8'h11, H_13 = 8'h2D, H_31 = 8'h87.
- The column for check bit j is the unit vector 1<<j.
- All 32 data columns are distinct, nonzero and not unit vectors.
- Syndrome: S[j] = IC_j XOR (XOR of ID_i over every i with H_i[j] = 1).
- Effective syndrome: Se = R ? S : 8'h00.
- Correction: c_i = (Se == H_i); OD_i_next = ID_i XOR c_i. At most one c_i is set.
- Boundary cases:
  - Se = 0: data passes through unchanged.
  - Se is a unit vector (single check-bit error): data passes through unchanged.
  - Se matches no column (multi-bit error): data passes through unchanged, with no flagging.
  - R = 0: data passes through unchanged regardless of IC.
- The correction logic is purely combinational from the inputs. The only state is the 32-bit output register.

## Timing
- The output register captures OD_next on every rising clk edge. Latency is 1 cycle from the input change to N724..N755.
- rst_n low clears all outputs to 0 immediately (asynchronously) and holds them there while low.
- On the first rising edge after rst_n deasserts, the register loads OD_next.
- Reset asserted mid-stream: outputs go to 0 at once. The vector that was pending is lost and is not replayed.
- Inputs must be stable a setup time before the rising edge. The combinational path must meet one 10 ns cycle.

## Structure
- The shared package holds:
  - DATA_W = 32 and CHK_W = 8.
  - A function/constant array returning H_i for i = 0..31.
  - A syndrome typedef logic [7:0].
- Natural sub-module: c499_syndrome (32 data + 8 check + R → Se), as a pure combinational XOR tree.
- The top level holds the column-match decode and the 32-bit output register.

## Test plan
- Reset: rst_n = 0 with arbitrary inputs → all outputs 0. Release, then ID = 32'hDEADBEEF, IC = its correct checks, R = 1 → one cycle later, outputs = 32'hDEADBEEF.
- Single data error: ID = 32'h0000_0001, IC = 8'h00, R = 1 → Se = 8'h11, outputs 32'h0. Then ID = 32'h0000_2000 → Se = 8'h2D, outputs 32'h0.
- Exhaustive single-bit sweep: for each i = 0..31 and a random codeword, flip ID_i → outputs equal the original codeword.
- Check-bit error: ID = 0, IC = 8'h04, R = 1 → outputs 32'h0 (no data bit flipped).
- Double error: ID = 32'h0000_0003, IC = 0, R = 1 → Se = 8'h03 matches no column → outputs 32'h0000_0003.
- Enable off: ID = 32'h0000_0001, IC = 0, R = 0 → outputs 32'h0000_0001. Assert rst_n = 0 mid-vector → outputs 0 with no wait for a clock edge.

Source files
------------

// File: rtl/c499_sec_pkg.sv
// c499_sec_pkg: shared constants, types and helpers for the c499-style
// 32-bit single-error-correcting decoder.
//   DATA_W / CHK_W : fixed data and check widths
//   syndrome_t     : 8-bit syndrome type
//   h_col(i)       : Hamming H-matrix column for data bit i
//   parity32(d)    : even parity over a 32-bit word
package c499_sec_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;

  typedef logic [CHK_W-1:0] syndrome_t;

  // Column for data bit i: upper nibble one-hot on the byte group, lower
  // nibble a unit vector for k<4 or an inverted unit vector for k>=4, so no
  // column is zero, a unit vector, or a duplicate.
  function automatic syndrome_t h_col(input int unsigned i);
    logic [3:0]  hi;
    logic [3:0]  lo;
    int unsigned k;
    k  = i % 32'd8;
    hi = 4'b0001 << (i / 32'd8);
    if (k < 32'd4) begin
      lo = 4'b0001 << k;
    end else begin
      lo = 4'hF ^ (4'b0001 << (k - 32'd4));
    end
    return {hi, lo};
  endfunction

  function automatic logic parity32(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/c499_sec_if.sv
// c499_sec_if: bit-level bus of the c499 decoder, keeping the benchmark's
// net names.
//   N1..N125 (step 4) : data bits ID0..ID31
//   N129..N136        : check bits IC0..IC7
//   N137              : correction enable R
//   N724..N755        : corrected data OD0..OD31
// master = stimulus side, slave = decoder side.
interface c499_sec_if;
  import c499_sec_pkg::*;

  logic N1, N5, N9, N13, N17, N21, N25, N29;
  logic N33, N37, N41, N45, N49, N53, N57, N61;
  logic N65, N69, N73, N77, N81, N85, N89, N93;
  logic N97, N101, N105, N109, N113, N117, N121, N125;
  logic N129, N130, N131, N132, N133, N134, N135, N136;
  logic N137;
  logic N724, N725, N726, N727, N728, N729, N730, N731;
  logic N732, N733, N734, N735, N736, N737, N738, N739;
  logic N740, N741, N742, N743, N744, N745, N746, N747;
  logic N748, N749, N750, N751, N752, N753, N754, N755;

  modport master (
    output N1, N5, N9, N13, N17, N21, N25, N29,
           N33, N37, N41, N45, N49, N53, N57, N61,
           N65, N69, N73, N77, N81, N85, N89, N93,
           N97, N101, N105, N109, N113, N117, N121, N125,
           N129, N130, N131, N132, N133, N134, N135, N136, N137,
    input  N724, N725, N726, N727, N728, N729, N730, N731,
           N732, N733, N734, N735, N736, N737, N738, N739,
           N740, N741, N742, N743, N744, N745, N746, N747,
           N748, N749, N750, N751, N752, N753, N754, N755
  );

  modport slave (
    input  N1, N5, N9, N13, N17, N21, N25, N29,
           N33, N37, N41, N45, N49, N53, N57, N61,
           N65, N69, N73, N77, N81, N85, N89, N93,
           N97, N101, N105, N109, N113, N117, N121, N125,
           N129, N130, N131, N132, N133, N134, N135, N136, N137,
    output N724, N725, N726, N727, N728, N729, N730, N731,
           N732, N733, N734, N735, N736, N737, N738, N739,
           N740, N741, N742, N743, N744, N745, N746, N747,
           N748, N749, N750, N751, N752, N753, N754, N755
  );

endinterface

// File: rtl/c499_sec_syndrome.sv
// c499_sec_syndrome: pure combinational XOR tree producing the effective
// syndrome.
//   i_id [31:0] : data word
//   i_ic [7:0]  : stored check bits
//   i_r         : correction enable
//   o_se [7:0]  : effective syndrome (zero when i_r is low)
module c499_sec_syndrome
  import c499_sec_pkg::*;
(
  input  logic [DATA_W-1:0] i_id,
  input  logic [CHK_W-1:0]  i_ic,
  input  logic              i_r,
  output syndrome_t         o_se
);

  syndrome_t w_s;

  // Each set data bit folds its H column into the stored check bits.
  always_comb begin
    syndrome_t w_col;
    w_s = i_ic;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_col = h_col(i);
      w_s   = w_s ^ (w_col & {CHK_W{i_id[i]}});
    end
  end

  // Gate the syndrome with the enable.
  always_comb begin
    if (i_r) begin
      o_se = w_s;
    end else begin
      o_se = 8'h00;
    end
  end

endmodule

// File: rtl/c499_sec.sv
// c499_sec: registered 32-bit SEC decoder.
//   clk    : rising-edge clock for the output register
//   rst_n  : asynchronous active-low reset, clears outputs
//   bus    : c499_sec_if.slave (data, check bits, enable in; corrected data out)
// Output = data XOR (one-hot match of syndrome against H columns), registered.
module c499_sec
  import c499_sec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  c499_sec_if.slave  bus
);

  logic [DATA_W-1:0] w_id;
  logic [CHK_W-1:0]  w_ic;
  syndrome_t         w_se;
  logic [DATA_W-1:0] w_flip;
  logic [DATA_W-1:0] w_od_next;
  logic [DATA_W-1:0] r_od;

  assign w_id = {bus.N125, bus.N121, bus.N117, bus.N113, bus.N109, bus.N105, bus.N101, bus.N97,
                 bus.N93,  bus.N89,  bus.N85,  bus.N81,  bus.N77,  bus.N73,  bus.N69,  bus.N65,
                 bus.N61,  bus.N57,  bus.N53,  bus.N49,  bus.N45,  bus.N41,  bus.N37,  bus.N33,
                 bus.N29,  bus.N25,  bus.N21,  bus.N17,  bus.N13,  bus.N9,   bus.N5,   bus.N1};
  assign w_ic = {bus.N136, bus.N135, bus.N134, bus.N133, bus.N132, bus.N131, bus.N130, bus.N129};

  c499_sec_syndrome u_syndrome (
    .i_id (w_id),
    .i_ic (w_ic),
    .i_r  (bus.N137),
    .o_se (w_se)
  );

  // Column match: zero, unit-vector and unmatched syndromes hit no column,
  // so the data passes through untouched in those cases.
  always_comb begin
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_flip[i] = (w_se == h_col(i));
    end
  end

  assign w_od_next = w_id ^ w_flip;

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_od <= 32'h0000_0000;
    end else begin
      r_od <= w_od_next;
    end
  end

  assign {bus.N755, bus.N754, bus.N753, bus.N752, bus.N751, bus.N750, bus.N749, bus.N748,
          bus.N747, bus.N746, bus.N745, bus.N744, bus.N743, bus.N742, bus.N741, bus.N740,
          bus.N739, bus.N738, bus.N737, bus.N736, bus.N735, bus.N734, bus.N733, bus.N732,
          bus.N731, bus.N730, bus.N729, bus.N728, bus.N727, bus.N726, bus.N725, bus.N724} = r_od;

endmodule

// File: tb/tb_c499_sec.sv
// tb_c499_sec: directed self-checking bench for c499_sec.
module tb_c499_sec;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  c499_sec_if bus ();

  c499_sec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Hand-tabulated H columns for data bits 0..31.
  localparam logic [7:0] H_TAB [32] = '{
    8'h11, 8'h12, 8'h14, 8'h18, 8'h1E, 8'h1D, 8'h1B, 8'h17,
    8'h21, 8'h22, 8'h24, 8'h28, 8'h2E, 8'h2D, 8'h2B, 8'h27,
    8'h41, 8'h42, 8'h44, 8'h48, 8'h4E, 8'h4D, 8'h4B, 8'h47,
    8'h81, 8'h82, 8'h84, 8'h88, 8'h8E, 8'h8D, 8'h8B, 8'h87
  };

  function automatic logic [7:0] gen_chk(input logic [31:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) c = c ^ H_TAB[i];
    end
    return c;
  endfunction

  task automatic drive(input logic [31:0] id, input logic [7:0] ic, input logic r);
    {bus.N125, bus.N121, bus.N117, bus.N113, bus.N109, bus.N105, bus.N101, bus.N97,
     bus.N93,  bus.N89,  bus.N85,  bus.N81,  bus.N77,  bus.N73,  bus.N69,  bus.N65,
     bus.N61,  bus.N57,  bus.N53,  bus.N49,  bus.N45,  bus.N41,  bus.N37,  bus.N33,
     bus.N29,  bus.N25,  bus.N21,  bus.N17,  bus.N13,  bus.N9,   bus.N5,   bus.N1} = id;
    {bus.N136, bus.N135, bus.N134, bus.N133, bus.N132, bus.N131, bus.N130, bus.N129} = ic;
    bus.N137 = r;
  endtask

  function automatic logic [31:0] read_od();
    return {bus.N755, bus.N754, bus.N753, bus.N752, bus.N751, bus.N750, bus.N749, bus.N748,
            bus.N747, bus.N746, bus.N745, bus.N744, bus.N743, bus.N742, bus.N741, bus.N740,
            bus.N739, bus.N738, bus.N737, bus.N736, bus.N735, bus.N734, bus.N733, bus.N732,
            bus.N731, bus.N730, bus.N729, bus.N728, bus.N727, bus.N726, bus.N725, bus.N724};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a vector on the falling edge, sample one rising edge later.
  task automatic apply(input string tag, input logic [31:0] id, input logic [7:0] ic,
                       input logic r, input logic [31:0] exp);
    @(negedge clk);
    drive(id, ic, r);
    @(posedge clk);
    #1;
    check(tag, read_od(), exp);
  endtask

  initial begin
    logic [31:0] cw;
    logic [7:0]  cc;
    logic [31:0] one;

    rst_n = 1'b1;
    drive(32'hFFFF_FFFF, 8'hFF, 1'b1);
    #1 rst_n = 1'b0;
    #2;
    check("reset_async", read_od(), 32'h0000_0000);
    #15;
    check("reset_hold", read_od(), 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply("codeword_deadbeef", 32'hDEAD_BEEF, gen_chk(32'hDEAD_BEEF), 1'b1, 32'hDEAD_BEEF);
    apply("sec_bit0", 32'h0000_0001, 8'h00, 1'b1, 32'h0000_0000);
    apply("sec_bit13", 32'h0000_2000, 8'h00, 1'b1, 32'h0000_0000);

    cw  = $urandom;
    cc  = gen_chk(cw);
    one = 32'h0000_0001;
    apply("sweep_clean", cw, cc, 1'b1, cw);
    for (int i = 0; i < 32; i++) begin
      apply($sformatf("sweep_bit%0d", i), cw ^ (one << i), cc, 1'b1, cw);
    end
    apply("sweep_chkbit4", cw, cc ^ 8'h10, 1'b1, cw);

    apply("chk_err", 32'h0000_0000, 8'h04, 1'b1, 32'h0000_0000);
    apply("double_err", 32'h0000_0003, 8'h00, 1'b1, 32'h0000_0003);
    apply("r_off", 32'h0000_0001, 8'h00, 1'b0, 32'h0000_0001);
    apply("r_off_bad_ic", 32'h0000_2000, 8'h2D ^ 8'h2D ^ 8'hFF, 1'b0, 32'h0000_2000);

    // Mid-vector reset: outputs clear without a clock edge.
    @(negedge clk);
    drive(32'hA5A5_0000, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_async", read_od(), 32'h0000_0000);
    @(posedge clk);
    #1;
    check("midreset_hold", read_od(), 32'h0000_0000);
    @(negedge clk);
    drive(32'h1234_5678, gen_chk(32'h1234_5678), 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_load", read_od(), 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
